// File: rtl/rhd_pkg.sv
// Shared types and command encoding for the RHD SPI sampler.
package rhd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  localparam logic [1:0] OP_CONVERT = 2'b00;

  function automatic logic [15:0] convert_cmd(input logic [5:0] ch);
    return {OP_CONVERT, ch, 8'h00};
  endfunction

endpackage

// File: rtl/rhd_spi_word.sv
// One 16-bit SPI word: SCLK generation, MSB-first MOSI shift, MISO capture.
module rhd_spi_word #(
  parameter int unsigned SCLK_HALF = 1
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cmd,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        done,
  output logic [15:0] rx_data
);

  localparam logic [3:0] HALF_LAST = 4'(SCLK_HALF - 1);

  logic        active;
  logic [3:0]  hcnt;
  logic [4:0]  half_idx;
  logic [15:0] tx_sr;
  logic        half_end;

  assign half_end = active && (hcnt == HALF_LAST);
  // The 32nd half-period ends with SCLK returning low; the word is complete.
  assign done     = half_end && (half_idx == 5'd31);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      active   <= 1'b0;
      hcnt     <= '0;
      half_idx <= '0;
      tx_sr    <= '0;
      rx_data  <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      hcnt     <= '0;
      half_idx <= '0;
      tx_sr    <= cmd;
      mosi     <= cmd[15];
      sck      <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        hcnt     <= '0;
        half_idx <= half_idx + 5'd1;
        sck      <= ~sck;
        if (!sck) begin
          rx_data <= {rx_data[14:0], miso};
        end else if (done) begin
          active <= 1'b0;
        end else begin
          tx_sr <= {tx_sr[14:0], 1'b0};
          mosi  <= tx_sr[14];
        end
      end else begin
        hcnt <= hcnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/rhd_spi_sampler.sv
// RHD acquisition sequencer: issues CONVERT frames and tags returned samples.
module rhd_spi_sampler
  import rhd_pkg::*;
#(
  parameter int unsigned NUM_CH    = 32,
  parameter int unsigned SCLK_HALF = 1,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        adc_en,
  input  logic        mode_cont,
  input  logic        rhd_miso,
  output logic        rhd_cs,
  output logic        rhd_sck,
  output logic        rhd_mosi,
  output logic [15:0] rhd_data,
  output logic [4:0]  rhd_ch,
  output logic        rhd_data_en,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned      WCW          = $clog2(NUM_CH + 2);
  localparam logic [WCW-1:0]   LAST_WORD    = WCW'(NUM_CH + 1);
  localparam logic [WCW-1:0]   NUM_CH_W     = WCW'(NUM_CH);
  localparam logic [WCW-1:0]   FIRST_TAGGED = WCW'(2);
  localparam logic [5:0]       GAP_LAST     = 6'(CS_GAP - 1);

  seq_state_t     state, state_nxt;
  logic [WCW-1:0] word_cnt;
  logic [5:0]     gap_cnt;
  logic           adc_en_q;
  logic           start_req;
  logic           gap_end;
  logic           frame_end;
  logic           word_done;
  logic [15:0]    cmd;
  logic [15:0]    rx_data;

  assign start_req = adc_en && (mode_cont || !adc_en_q);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
  assign frame_end = gap_end && (word_cnt == LAST_WORD);
  // The two trailing words re-issue CONVERT(0) only to flush the RHD pipeline.
  assign cmd       = (word_cnt < NUM_CH_W) ? convert_cmd(6'(word_cnt)) : convert_cmd(6'd0);
  assign busy      = (state != IDLE);

  rhd_spi_word #(
    .SCLK_HALF(SCLK_HALF)
  ) u_word (
    .sysclk  (sysclk),
    .rst     (rst),
    .start   (state == SETUP),
    .cmd     (cmd),
    .miso    (rhd_miso),
    .sck     (rhd_sck),
    .mosi    (rhd_mosi),
    .done    (word_done),
    .rx_data (rx_data)
  );

  always_ff @(posedge sysclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = SETUP;
      SETUP:   state_nxt = SHIFT;
      SHIFT:   if (word_done) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = (!frame_end || (mode_cont && adc_en)) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      word_cnt    <= '0;
      gap_cnt     <= '0;
      adc_en_q    <= 1'b0;
      rhd_cs      <= 1'b1;
      rhd_data    <= '0;
      rhd_ch      <= '0;
      rhd_data_en <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      adc_en_q    <= adc_en;
      rhd_cs      <= !((state_nxt == SETUP) || (state_nxt == SHIFT));
      rhd_data_en <= 1'b0;
      frame_done  <= 1'b0;
      // Word k carries the result of the CONVERT issued two words earlier.
      if ((state == SHIFT) && word_done && (word_cnt >= FIRST_TAGGED)) begin
        rhd_data    <= rx_data;
        rhd_ch      <= 5'(word_cnt - FIRST_TAGGED);
        rhd_data_en <= 1'b1;
        frame_done  <= (word_cnt == LAST_WORD);
      end
      if (state == GAP) gap_cnt <= gap_end ? '0 : gap_cnt + 6'd1;
      if (gap_end) word_cnt <= frame_end ? '0 : word_cnt + WCW'(1);
    end
  end

endmodule

// File: tb/tb_rhd_spi_sampler.sv
// Bench for rhd_spi_sampler: RHD/SPI reference model per DUT plus scenario table.
module tb_rhd_spi_sampler;

  logic        sysclk, rst;
  logic        adc0, mode0, adc1, mode1;
  logic        miso_drv [2];
  logic        cs0, sck0, mosi0, den0, fd0, busy0;
  logic [15:0] data0;
  logic [4:0]  ch0;
  logic        cs1, sck1, mosi1, den1, fd1, busy1;
  logic [15:0] data1;
  logic [4:0]  ch1;

  rhd_spi_sampler dut0 (
    .sysclk(sysclk), .rst(rst), .adc_en(adc0), .mode_cont(mode0), .rhd_miso(miso_drv[0]),
    .rhd_cs(cs0), .rhd_sck(sck0), .rhd_mosi(mosi0), .rhd_data(data0), .rhd_ch(ch0),
    .rhd_data_en(den0), .frame_done(fd0), .busy(busy0)
  );

  rhd_spi_sampler #(.NUM_CH(4), .SCLK_HALF(2), .CS_GAP(3)) dut1 (
    .sysclk(sysclk), .rst(rst), .adc_en(adc1), .mode_cont(mode1), .rhd_miso(miso_drv[1]),
    .rhd_cs(cs1), .rhd_sck(sck1), .rhd_mosi(mosi1), .rhd_data(data1), .rhd_ch(ch1),
    .rhd_data_en(den1), .frame_done(fd1), .busy(busy1)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic miso_stuck   = 1'b0;
  logic resp_ch_mode = 1'b0;

  int nchv  [2] = '{32, 4};
  int halfv [2] = '{1, 2};
  int gapv  [2] = '{4, 3};

  int          widx [2], bitn [2], cs_high [2], last_fall [2];
  int          words [2], strobes [2], frames [2];
  logic        pcs [2], psck [2], pmosi [2], pending [2], exp_last [2];
  logic [15:0] resp [2], mosiw [2], exp_data [2];
  logic [4:0]  exp_ch [2];
  logic [5:0]  cmdch [2][34];

  function automatic string nm(input string s, input int d);
    return $sformatf("%s[dut%0d]", s, d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RHD slave model and SPI protocol checker, sampled mid-cycle.
  task automatic mon_step(input int d, input logic cs, input logic sck, input logic mosi,
                          input logic den, input logic fd, input logic [15:0] data,
                          input logic [4:0] ch);
    logic [15:0] exp_cmd;
    logic [5:0]  chf;
    if (rst) begin
      widx[d] = 0; bitn[d] = 0; cs_high[d] = 0; pending[d] = 1'b0;
      pcs[d] = 1'b1; psck[d] = 1'b0; pmosi[d] = 1'b0; miso_drv[d] = 1'b0;
    end else begin
      if (pcs[d] && !cs) begin
        if (widx[d] != 0) begin
          check(nm("cs_gap", d), 32'(cs_high[d]), 32'(gapv[d]));
          check(nm("word_spacing", d), 32'(cyc - last_fall[d]), 32'(1 + 32 * halfv[d] + gapv[d]));
        end
        last_fall[d] = cyc;
        cs_high[d]   = 0;
        bitn[d]      = 0;
        mosiw[d]     = '0;
        if (miso_stuck)        resp[d] = 16'h0000;
        else if (resp_ch_mode) resp[d] = (widx[d] >= 2) ? 16'h8000 + 16'(cmdch[d][widx[d] - 2]) : 16'h8000;
        else                   resp[d] = 16'($urandom);
        miso_drv[d] = resp[d][15];
        words[d]++;
      end else if (!cs && !psck[d] && sck) begin
        check(nm("mosi_stable", d), 32'(mosi), 32'(pmosi[d]));
        mosiw[d] = {mosiw[d][14:0], mosi};
        bitn[d]++;
        miso_drv[d] = (bitn[d] < 16) ? resp[d][15 - bitn[d]] : 1'b0;
      end else if (!pcs[d] && cs) begin
        check(nm("sclk_edges", d), 32'(bitn[d]), 32'd16);
        check(nm("cs_low_len", d), 32'(cyc - last_fall[d]), 32'(1 + 32 * halfv[d]));
        chf     = 6'(widx[d]);
        exp_cmd = (widx[d] < nchv[d]) ? {2'b00, chf, 8'h00} : 16'h0000;
        check(nm("mosi_word", d), 32'(mosiw[d]), 32'(exp_cmd));
        cmdch[d][widx[d]] = mosiw[d][13:8];
        if (widx[d] >= 2) begin
          pending[d]  = 1'b1;
          exp_data[d] = resp[d];
          exp_ch[d]   = 5'(widx[d] - 2);
          exp_last[d] = (widx[d] == nchv[d] + 1);
        end
        widx[d]++;
        if (widx[d] == nchv[d] + 2) widx[d] = 0;
      end
      if (cs) begin
        cs_high[d]++;
        check(nm("sck_idle", d), 32'(sck), 32'd0);
      end
      if (den || pending[d]) begin
        check(nm("strobe_at_word_end", d), 32'(den), 32'(pending[d]));
        if (den && pending[d]) begin
          check(nm("rhd_data", d), 32'(data), 32'(exp_data[d]));
          check(nm("rhd_ch", d), 32'(ch), 32'(exp_ch[d]));
          check(nm("frame_done", d), 32'(fd), 32'(exp_last[d]));
          if (resp_ch_mode) check(nm("data_8000_ch", d), 32'(data), 32'(16'h8000 + 16'(exp_ch[d])));
        end
        pending[d] = 1'b0;
      end
      if (fd) check(nm("frame_done_with_strobe", d), 32'(den), 32'd1);
      if (den) strobes[d]++;
      if (den && fd) frames[d]++;
      pcs[d] = cs; psck[d] = sck; pmosi[d] = mosi;
    end
  endtask

  always @(negedge sysclk) begin
    cyc++;
    mon_step(0, cs0, sck0, mosi0, den0, fd0, data0, ch0);
    mon_step(1, cs1, sck1, mosi1, den1, fd1, data1, ch1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic wait_idle(input int d, input int bound);
    for (int i = 0; i < bound && ((d == 0) ? busy0 : busy1); i++) cycles(1);
    check(nm("idle_reached", d), 32'((d == 0) ? busy0 : busy1), 32'd0);
  endtask

  typedef struct {
    logic cont;
    int   hold;
    logic stuck;
    int   frames;
  } vec_t;

  initial begin
    vec_t vecs [9];
    int   s, w, f, lowcnt, j;

    // dut1 frame = 6 words x 68 cycles = 408 cycles; holds stay clear of frame ends.
    vecs[0] = '{cont: 1'b0, hold: 3,   stuck: 1'b0, frames: 1};
    vecs[1] = '{cont: 1'b0, hold: 900, stuck: 1'b0, frames: 1};
    vecs[2] = '{cont: 1'b0, hold: 2,   stuck: 1'b1, frames: 1};
    vecs[3] = '{cont: 1'b1, hold: 1,   stuck: 1'b0, frames: 1};
    vecs[4] = '{cont: 1'b1, hold: 560, stuck: 1'b0, frames: 2};
    vecs[5] = '{cont: 1'b1, hold: 1000, stuck: 1'b0, frames: 3};
    for (int i = 6; i < 9; i++) begin
      j              = int'($urandom_range(2, 0));
      vecs[i].cont   = 1'($urandom_range(1, 0));
      vecs[i].hold   = 408 * j + int'($urandom_range(350, 50));
      vecs[i].stuck  = 1'($urandom_range(1, 0));
      vecs[i].frames = vecs[i].cont ? j + 1 : 1;
    end

    rst = 1'b1; adc0 = 1'b0; mode0 = 1'b0; adc1 = 1'b0; mode1 = 1'b0;
    cycles(3);
    check("reset_cs", 32'(cs0), 32'd1);
    check("reset_sck", 32'(sck0), 32'd0);
    check("reset_mosi", 32'(mosi0), 32'd0);
    check("reset_data", 32'(data0), 32'd0);
    check("reset_ch", 32'(ch0), 32'd0);
    check("reset_data_en", 32'(den0), 32'd0);
    check("reset_frame_done", 32'(fd0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_cs_dut1", 32'(cs1), 32'd1);
    check("reset_busy_dut1", 32'(busy1), 32'd0);
    rst = 1'b0;
    cycles(2);

    // Continuous frames with an RHD answering 0x8000 + channel.
    resp_ch_mode = 1'b1; mode0 = 1'b1;
    s = strobes[0]; w = words[0]; f = frames[0];
    adc0 = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 1400 && frames[0] != f + k; i++) cycles(1);
      check("cont_frames_seen", 32'(frames[0] - f), 32'(k));
      check("cont_strobes", 32'(strobes[0] - s), 32'(32 * k));
      check("cont_words", 32'(words[0] - w), 32'(34 * k));
    end
    adc0 = 1'b0;
    cycles(3);
    wait_idle(0, 200);
    check("cont_stop_words", 32'(words[0] - w), 32'd68);
    resp_ch_mode = 1'b0;

    // adc_en drops during word 10: the frame still completes.
    s = strobes[0]; w = words[0];
    adc0 = 1'b1;
    for (int i = 0; i < 600 && !(widx[0] == 10 && cs0 == 1'b0); i++) cycles(1);
    check("reached_word10", 32'(widx[0]), 32'd10);
    adc0 = 1'b0;
    wait_idle(0, 1300);
    check("drop_words", 32'(words[0] - w), 32'd34);
    check("drop_strobes", 32'(strobes[0] - s), 32'd32);
    lowcnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (cs0 == 1'b0) lowcnt++;
    end
    check("cs_stays_high", 32'(lowcnt), 32'd0);

    // MISO stuck low: captured data must be zero regardless of MOSI.
    miso_stuck = 1'b1; mode0 = 1'b0;
    s = strobes[0];
    adc0 = 1'b1; cycles(2); adc0 = 1'b0;
    cycles(5);
    wait_idle(0, 1400);
    check("stuck_strobes", 32'(strobes[0] - s), 32'd32);
    check("stuck_last_data", 32'(data0), 32'd0);
    miso_stuck = 1'b0;

    // Reset in the SHIFT phase of word 5 aborts the word.
    mode0 = 1'b1; adc0 = 1'b1;
    for (int i = 0; i < 400 && !(widx[0] == 5 && cs0 == 1'b0 && bitn[0] >= 3); i++) cycles(1);
    check("reached_word5_shift", 32'(widx[0]), 32'd5);
    rst = 1'b1;
    cycles(1);
    check("abort_cs", 32'(cs0), 32'd1);
    check("abort_sck", 32'(sck0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_data_en", 32'(den0), 32'd0);
    cycles(1);
    adc0 = 1'b0; rst = 1'b0;
    s = strobes[0];
    cycles(300);
    check("no_strobe_after_abort", 32'(strobes[0] - s), 32'd0);
    check("abort_stays_idle", 32'(busy0), 32'd0);

    // Scenario table on the 4-channel instance.
    for (int i = 0; i < 9; i++) begin
      miso_stuck = vecs[i].stuck; mode1 = vecs[i].cont;
      cycles(2);
      s = strobes[1]; w = words[1]; f = frames[1];
      adc1 = 1'b1;
      cycles(vecs[i].hold);
      adc1 = 1'b0;
      cycles(3);
      wait_idle(1, 3000);
      check($sformatf("vec%0d_words", i), 32'(words[1] - w), 32'(6 * vecs[i].frames));
      check($sformatf("vec%0d_strobes", i), 32'(strobes[1] - s), 32'(4 * vecs[i].frames));
      check($sformatf("vec%0d_frames", i), 32'(frames[1] - f), 32'(vecs[i].frames));
      check($sformatf("vec%0d_cs_idle", i), 32'(cs1), 32'd1);
    end
    miso_stuck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: end of test not reached, %0d failures so far", n_fail);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/rhd_spi_sampler.md
RHD_SPI_SAMPLER -- requirements
Module: rhd_spi_sampler

Interface
REQ-001 SHALL have parameter NUM_CH, default 32: channels converted per frame, range 1..32.
REQ-002 SHALL have parameter SCLK_HALF, default 1: sysclk cycles per SCLK half-period, range 1..15.
REQ-003 SHALL have parameter CS_GAP, default 4: sysclk cycles rhd_cs stays high between words, range 2..63.
REQ-004 SHALL have port sysclk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port adc_en, input, 1 bit: level enable for acquisition.
REQ-007 SHALL have port mode_cont, input, 1 bit: 1 = back-to-back frames, 0 = one frame per adc_en rising edge.
REQ-008 SHALL have port rhd_miso, input, 1 bit: serial data from the RHD.
REQ-009 SHALL have ports rhd_cs, rhd_sck and rhd_mosi, outputs, 1 bit each: SPI chip select (active low), clock and master data, all registered.
REQ-010 SHALL have port rhd_data, output, 16 bits: captured conversion result.
REQ-011 SHALL have port rhd_ch, output, 5 bits: channel index of rhd_data.
REQ-012 SHALL have port rhd_data_en, output, 1 bit: one-cycle strobe marking rhd_data/rhd_ch valid.
REQ-013 SHALL have ports frame_done (1-cycle pulse after the last word of a frame) and busy (high while not IDLE), outputs, 1 bit each.

Function
REQ-014 SHALL run states IDLE, SETUP, SHIFT, GAP: IDLE->SETUP on start, SETUP->SHIFT after 1 cycle, SHIFT->GAP after 16 bits, GAP->SETUP or IDLE after CS_GAP cycles.
REQ-015 SHALL start a frame, in mode_cont=1, whenever adc_en=1 in IDLE, and in mode_cont=0 only on a registered 0->1 edge of adc_en.
REQ-016 SHALL issue NUM_CH+2 words per frame, word k = CONVERT(k) = {2'b00, k[5:0], 8'h00} for k<NUM_CH, and the last two words CONVERT(0) as pipeline flush.
REQ-017 SHALL hold rhd_cs low in SETUP and SHIFT and high in IDLE and GAP.
REQ-018 SHALL keep rhd_sck low outside SHIFT and toggle it every SCLK_HALF cycles in SHIFT, giving 16 rising edges per word and ending low.
REQ-019 SHALL present rhd_mosi MSB first, updating it in SETUP for bit 15 and on each SCLK falling edge thereafter.
REQ-020 SHALL shift rhd_miso into a 16-bit register (MSB first) on the sysclk edge at which rhd_sck rises; MOSI SHALL never be looped back into the capture path.
REQ-021 SHALL treat word k>=2 as the result of channel k-2: load rhd_data, load rhd_ch=k-2 and pulse rhd_data_en for one cycle on the first GAP cycle; words 0 and 1 SHALL produce no strobe.
REQ-022 SHALL emit exactly NUM_CH strobes per frame with rhd_ch ascending 0..NUM_CH-1, and pulse frame_done together with the last strobe.
REQ-023 SHALL complete the current frame when adc_en falls mid-frame and then enter IDLE, never truncating a word.
REQ-024 SHALL in mode_cont=1 go GAP->SETUP into the next frame, with the word counter wrapping to 0, when adc_en=1 at frame end.
REQ-025 SHALL make a word last 2+32*SCLK_HALF+CS_GAP... more precisely 1 (SETUP) + 32*SCLK_HALF (SHIFT) + CS_GAP (GAP) sysclk cycles; with defaults, 37 cycles.
REQ-026 SHALL size the word counter to $clog2(NUM_CH+2) bits and fix the 6-bit channel field of the command by zero-extension.

Reset
REQ-027 SHALL on rst=1 force, at the next sysclk edge, state=IDLE, rhd_cs=1, rhd_sck=0, rhd_mosi=0, rhd_data=0, rhd_ch=0, rhd_data_en=0, frame_done=0, busy=0, all counters=0 and the edge register=0.
REQ-028 SHALL abort immediately on rst asserted mid-word, with no strobe for the aborted word.

Structure
REQ-029 SHALL take the state enum, the CONVERT opcode (2'b00) and the command-build function from the shared package rhd_pkg.
REQ-030 SHALL place the 16-bit SCLK/MOSI/MISO shifter in one sub-module, rhd_spi_word, with start/done handshake; the sequencer, counters and tagging SHALL stay in the top level.

Verification
REQ-031 SHALL cover this scenario: defaults, mode_cont=1, adc_en=1 with an RHD model returning 16'h8000+ch -> 32 strobes per frame, rhd_data=16'h8000..16'h801F, rhd_ch 0..31, frame_done with ch 31, 34 CS-low periods, 37-cycle word spacing.
REQ-032 SHALL cover this scenario: NUM_CH=4, SCLK_HALF=2, mode_cont=0, a single adc_en pulse -> 6 words, 4 strobes, MOSI words 0000,0100,0200,0300,0000,0000, then IDLE with busy=0.
REQ-033 SHALL cover this scenario: adc_en falls during word 10 -> the frame completes all 34 words, then rhd_cs stays 1.
REQ-034 SHALL cover this scenario: rst during SHIFT of word 5 -> the next cycle rhd_cs=1, rhd_sck=0, and no further strobe until a new start.
REQ-035 SHALL cover this scenario: rhd_miso stuck 0 and rhd_mosi toggling -> every rhd_data=0, proving no loopback.
REQ-036 SHALL cover this scenario: SPI checker on every word -> exactly 16 SCLK rising edges, MOSI stable across each rising edge, CS high for CS_GAP cycles.
